lfsr_checker: RTL and testbench

Receive-side PRBS checker for the 10-bit XNOR LFSR stream (taps 9 and 6, newest bit = q[9] XNOR q[6]). It takes the serial bit stream produced by the LFSR generator, self-synchronises to it, then flywheels a local predictor and flags every mismatching bit. It sits at the far end of a link or loopback under test and reports lock status and a bit-error count.

---
 rtl/lfsr_pkg.sv | 26 ++
 rtl/sat_counter.sv | 38 +++
 rtl/lfsr_checker.sv | 153 +++++++++++++++
 tb/tb_lfsr_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 10-bit XNOR PRBS link: LFSR geometry, the
// lock-up pattern, block length for loss-of-lock accounting, checker states
// and the next-bit predictor.
package lfsr_pkg;

  localparam int unsigned LFSR_W    = 10;
  localparam int unsigned TAP_HI    = 9;
  localparam int unsigned TAP_LO    = 6;
  localparam int unsigned BLOCK_LEN = 32;
  localparam int unsigned BLOCK_W   = $clog2(BLOCK_LEN);

  // All-ones is the XNOR LFSR's stuck state; a real stream never visits it.
  localparam logic [LFSR_W-1:0] LOCKUP = 10'h3FF;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Next bit of the stream given the current register (s[0] newest).
  function automatic logic predict(input logic [LFSR_W-1:0] s);
    return ~(s[TAP_HI] ^ s[TAP_LO]);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over the held
// value, then the increment is applied, so clear+inc yields 1.
// Ports: clk, reset (sync, active-high), clear, inc, count[CNT_W-1:0].
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear first, then increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end
    if (inc && (count_d != '1)) begin
      count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 10-bit XNOR PRBS (taps 9, 6). Self-synchronises
// on the incoming stream, then flywheels a local predictor and flags every
// mismatching bit while locked.
// Ports: clk, reset (sync, active-high), bit_in, bit_valid, clear_count ->
//        locked, err (one-cycle pulse), err_count[CNT_W-1:0].
// Build option: define LFSR_CHECKER_ERRCNT_EN to build err_count/clear_count;
//               otherwise err_count is tied to 0 and clear_count is ignored.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_MATCHES = 16,
  parameter int unsigned LOSS_ERRORS  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_count,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned FILL_W  = 4;
  localparam int unsigned MATCH_W = 8;
  localparam int unsigned BERR_W  = BLOCK_W + 1;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   s_q, s_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
  logic [BLOCK_W-1:0]  block_cnt_q, block_cnt_d;
  logic [BERR_W-1:0]   block_err_q, block_err_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;

  logic                pred_c;
  logic                mismatch_c;
  logic [MATCH_W-1:0]  match_inc_c;
  logic [BERR_W-1:0]   block_err_inc_c;

  assign pred_c          = predict(s_q);
  assign mismatch_c      = bit_in ^ pred_c;
  assign match_inc_c     = match_cnt_q + MATCH_W'(1);
  assign block_err_inc_c = block_err_q + BERR_W'(mismatch_c);

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEARCH;
      s_q         <= '0;
      fill_q      <= '0;
      match_cnt_q <= '0;
      block_cnt_q <= '0;
      block_err_q <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      match_cnt_q <= match_cnt_d;
      block_cnt_q <= block_cnt_d;
      block_err_q <= block_err_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered-output logic; nothing moves without bit_valid.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    match_cnt_d = match_cnt_q;
    block_cnt_d = block_cnt_q;
    block_err_d = block_err_q;
    err_d       = 1'b0;

    if (bit_valid) begin
      case (state_q)
        SEARCH: begin
          s_d    = {s_q[LFSR_W-2:0], bit_in};
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            state_d     = VERIFY;
            match_cnt_d = '0;
          end
        end

        VERIFY: begin
          // Shifting the received bit keeps re-seeding until predictions hold.
          s_d = {s_q[LFSR_W-2:0], bit_in};
          if (mismatch_c || (s_q == LOCKUP)) begin
            match_cnt_d = '0;
          end else if (32'(match_inc_c) == LOCK_MATCHES) begin
            state_d     = LOCKED;
            match_cnt_d = '0;
            block_cnt_d = '0;
            block_err_d = '0;
          end else begin
            match_cnt_d = match_inc_c;
          end
        end

        LOCKED: begin
          // Flywheel: shift the prediction so line errors do not pollute s.
          s_d         = {s_q[LFSR_W-2:0], pred_c};
          err_d       = mismatch_c;
          block_cnt_d = block_cnt_q + BLOCK_W'(1);
          if (block_cnt_q == BLOCK_W'(BLOCK_LEN - 1)) begin
            block_err_d = '0;
            if (32'(block_err_inc_c) >= LOSS_ERRORS) begin
              state_d     = SEARCH;
              fill_d      = '0;
              match_cnt_d = '0;
            end
          end else begin
            block_err_d = block_err_inc_c;
          end
        end

        default: begin
          state_d = SEARCH;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  assign locked = locked_q;
  assign err    = err_q;

`ifdef LFSR_CHECKER_ERRCNT_EN
  // Counts the same events that raise err.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_count),
    .inc   (err_d),
    .count (err_count)
  );
`else
  logic unused_clear_c;
  assign unused_clear_c = clear_count;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: clean lock, single and burst errors,
// loss/relock, lock-up immunity, gapped valid, reset and clear priority.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_in;
  logic        bit_valid;
  logic        clear_count;
  logic        locked;
  logic        err;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  logic [9:0] g;      // transmit-side generator state
  int         k;      // valid bits since lock

`ifdef LFSR_CHECKER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  lfsr_checker #(
    .LOCK_MATCHES (16),
    .LOSS_ERRORS  (4),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .clear_count (clear_count),
    .locked      (locked),
    .err         (err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ec(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic v, input logic clr);
    @(negedge clk);
    bit_in      = b;
    bit_valid   = v;
    clear_count = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_next(output logic b);
    b = ~(g[9] ^ g[6]);
    g = {g[8:0], b};
  endtask

  task automatic send_gen(input logic inv, input logic clr);
    logic b;
    gen_next(b);
    send(b ^ inv, 1'b1, clr);
    k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bit_valid   = 1'b0;
    bit_in      = 1'b0;
    clear_count = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
    g     = '0;
    k     = 0;
  endtask

  initial begin
    int   lock_at;
    int   lock_cyc;
    int   cyc;
    int   nvalid;
    int   err_seen;
    int   lost;
    int   seen_lock;
    logic b;

    reset       = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    clear_count = 1'b0;
    g           = '0;
    k           = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_count", 32'(err_count), 0);

    // Clean stream: lock on the 26th bit, then 1023 bits without error.
    do_reset();
    lock_at = 0; err_seen = 0; lost = 0;
    for (int i = 1; i <= 1023; i++) begin
      send_gen(1'b0, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
      if (lock_at != 0 && !locked) lost++;
      if (err) err_seen++;
    end
    k = 1023 - lock_at;
    chk("clean_lock_at", 32'(lock_at), 26);
    chk("clean_err_pulses", 32'(err_seen), 0);
    chk("clean_err_count", 32'(err_count), 0);
    chk("clean_lock_held", 32'(lost), 0);

    // Single inverted bit: one pulse, count 1, lock kept, flywheel intact.
    repeat (5) send_gen(1'b0, 1'b0);
    send_gen(1'b1, 1'b0);
    chk("single_err_pulse", 32'(err), 1);
    chk("single_err_count", 32'(err_count), ec(1));
    chk("single_locked", 32'(locked), 1);
    send_gen(1'b0, 1'b0);
    chk("single_err_clears", 32'(err), 0);
    err_seen = 0;
    for (int i = 0; i < 64; i++) begin
      send_gen(1'b0, 1'b0);
      if (err) err_seen++;
    end
    chk("single_after_errs", 32'(err_seen), 0);
    chk("single_after_locked", 32'(locked), 1);

    // Align to a block start, clear the count with no valid bit.
    while (k % 32 != 0) send_gen(1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    chk("clear_idle", 32'(err_count), 0);

    // Three errors in a block: below threshold, lock kept.
    for (int p = 1; p <= 32; p++) send_gen((p == 2 || p == 5 || p == 9), 1'b0);
    chk("three_err_locked", 32'(locked), 1);
    chk("three_err_count", 32'(err_count), ec(3));
    send(1'b0, 1'b0, 1'b1);

    // Four errors in a block: lock falls after the 32nd bit.
    err_seen = 0;
    for (int p = 1; p <= 32; p++) begin
      send_gen((p == 3 || p == 10 || p == 17 || p == 24), 1'b0);
      if (err) err_seen++;
      if (p == 31) chk("four_err_pos31_locked", 32'(locked), 1);
    end
    chk("four_err_unlocked", 32'(locked), 0);
    chk("four_err_pulses", 32'(err_seen), 4);
    chk("four_err_count", 32'(err_count), ec(4));

    // Relock on the resumed clean stream after 26 bits.
    lock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      send_gen(1'b0, 1'b0);
      if (locked && lock_at == 0) lock_at = i;
    end
    chk("relock_at", 32'(lock_at), 26);

    // Clear together with a counted mismatch gives 1.
    send_gen(1'b1, 1'b1);
    chk("clear_inc_err", 32'(err), 1);
    chk("clear_inc_count", 32'(err_count), ec(1));
    chk("clear_inc_locked", 32'(locked), 1);

    // Reset mid-LOCKED with a bad valid bit on the same edge.
    @(negedge clk);
    reset       = 1'b1;
    bit_valid   = 1'b1;
    clear_count = 1'b0;
    gen_next(b);
    bit_in      = ~b;
    @(posedge clk);
    #1;
    chk("midrst_locked", 32'(locked), 0);
    chk("midrst_err", 32'(err), 0);
    chk("midrst_err_count", 32'(err_count), 0);
    @(negedge clk);
    reset     = 1'b0;
    bit_valid = 1'b0;
    g         = '0;
    k         = 0;

    // Alternating bit_valid; invalid cycles carry the wrong bit.
    lock_at = 0; lock_cyc = 0; cyc = 0; nvalid = 0; err_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) begin
        send_gen(1'b0, 1'b0);
        nvalid++;
      end else begin
        send(~(~(g[9] ^ g[6])), 1'b0, 1'b0);
      end
      cyc++;
      if (locked && lock_at == 0) begin
        lock_at  = nvalid;
        lock_cyc = cyc;
      end
      if (err) err_seen++;
    end
    chk("gap_lock_valid_bits", 32'(lock_at), 26);
    chk("gap_lock_cycles", 32'(lock_cyc), 51);
    chk("gap_err_pulses", 32'(err_seen), 0);

    // Constant ones: stuck in lock-up, never locks.
    do_reset();
    seen_lock = 0; err_seen = 0;
    for (int i = 0; i < 200; i++) begin
      send(1'b1, 1'b1, 1'b0);
      if (locked) seen_lock++;
      if (err) err_seen++;
    end
    chk("ones_never_lock", 32'(seen_lock), 0);
    chk("ones_no_err", 32'(err_seen), 0);
    chk("ones_s_lockup", 32'(dut.s_q), 32'h3FF);
    chk("ones_match_cnt", 32'(dut.match_cnt_q), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
